// File: rtl/mmio_bridge_pkg.sv
// Shared types and defaults for the CPU-to-device MMIO bridge.
package mmio_bridge_pkg;

   localparam int unsigned WordW       = 32;
   localparam logic [31:0] DefBaseAddr = 32'h0000_7F00;
   localparam int unsigned DefSpanLog2 = 4;

   typedef enum logic [0:0] {StIdle, StAcc} state_e;

   // Width of a device index; at least one bit so a single device still has a port.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational window decode: maps a CPU byte address to a device hit and index.
module mmio_addr_decode
   import mmio_bridge_pkg::*;
#(
   parameter int unsigned NDEV      = 3,
   parameter logic [31:0] BASE_ADDR = DefBaseAddr,
   parameter int unsigned SPAN_LOG2 = DefSpanLog2,
   localparam int unsigned IdxW     = idx_width(NDEV)
) (
   input  logic [WordW-1:0] addr_i,
   output logic             hit_o,
   output logic [IdxW-1:0]  idx_o
);

   localparam int unsigned TagW = WordW - SPAN_LOG2;

   logic [TagW-1:0]      diff;
   logic [SPAN_LOG2-1:0] unused_addr;

   // Unsigned difference: addresses below the base wrap to huge values and miss.
   assign diff        = addr_i[WordW-1:SPAN_LOG2] - BASE_ADDR[WordW-1:SPAN_LOG2];
   assign hit_o       = (diff < TagW'(NDEV));
   assign idx_o       = diff[IdxW-1:0];
   assign unused_addr = addr_i[SPAN_LOG2-1:0];

endmodule

// File: rtl/mmio_bridge.sv
// MMIO bridge: decodes CPU requests onto one-hot device strobes and returns data/errors.
// Optional device-wait timeout enabled by defining MMIO_BRIDGE_TIMEOUT_EN.
module mmio_bridge
   import mmio_bridge_pkg::*;
#(
   parameter int unsigned NDEV        = 3,
   parameter logic [31:0] BASE_ADDR   = DefBaseAddr,
   parameter int unsigned SPAN_LOG2   = DefSpanLog2,
   parameter int unsigned NINT        = 6,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WordW-1:0]        praddr,
   input  logic [WordW-1:0]        wdin,
   input  logic                    wecpu,
   input  logic                    recpu,
   output logic [WordW-1:0]        rd,
   output logic                    done,
   output logic                    buserr,
   output logic                    busy,
   output logic [SPAN_LOG2-3:0]    outaddr,
   output logic [WordW-1:0]        wdout,
   output logic [NDEV-1:0]         dev_we,
   output logic [NDEV-1:0]         dev_re,
   input  logic [NDEV*WordW-1:0]   dev_rd,
   input  logic [NDEV-1:0]         dev_ready,
   input  logic [NINT-1:0]         hwintin,
   output logic [NINT-1:0]         hwintout
);

   localparam int unsigned IdxW = idx_width(NDEV);

   if (NDEV < 1 || NDEV > 8 || SPAN_LOG2 < 3 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("mmio_bridge: parameter out of range");
   end

   state_e               state_q;
   logic [IdxW-1:0]      idx_q;
   logic                 we_q;
   logic [WordW-1:0]     rd_q;
   logic                 done_q;
   logic                 buserr_q;
   logic                 busy_q;
   logic [SPAN_LOG2-3:0] outaddr_q;
   logic [WordW-1:0]     wdout_q;
   logic [NDEV-1:0]      dev_we_q;
   logic [NDEV-1:0]      dev_re_q;
   logic [NINT-1:0]      hwint_q;

`ifdef MMIO_BRIDGE_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   logic [CntW-1:0]      cnt_q;
`endif

   logic                 dec_hit;
   logic [IdxW-1:0]      dec_idx;
   logic [NDEV-1:0]      dec_oh;
   logic [WordW-1:0]     rd_sel;
   logic                 ready_sel;

   mmio_addr_decode #(
      .NDEV      (NDEV),
      .BASE_ADDR (BASE_ADDR),
      .SPAN_LOG2 (SPAN_LOG2)
   ) u_decode (
      .addr_i (praddr),
      .hit_o  (dec_hit),
      .idx_o  (dec_idx)
   );

   always_comb begin
      dec_oh    = '0;
      rd_sel    = '0;
      ready_sel = 1'b0;
      for (int i = 0; i < NDEV; i++) begin
         dec_oh[i] = (dec_idx == IdxW'(i));
         if (idx_q == IdxW'(i)) begin
            rd_sel    = dev_rd[i*WordW +: WordW];
            ready_sel = dev_ready[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         we_q      <= 1'b0;
         rd_q      <= '0;
         done_q    <= 1'b0;
         buserr_q  <= 1'b0;
         busy_q    <= 1'b0;
         outaddr_q <= '0;
         wdout_q   <= '0;
         dev_we_q  <= '0;
         dev_re_q  <= '0;
         hwint_q   <= '0;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         hwint_q  <= hwintin;
         done_q   <= 1'b0;
         buserr_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // done_q high marks the completion cycle; the CPU is still dropping its request.
               if ((wecpu || recpu) && !done_q) begin
                  if (dec_hit) begin
                     state_q   <= StAcc;
                     idx_q     <= dec_idx;
                     we_q      <= wecpu;
                     outaddr_q <= praddr[SPAN_LOG2-1:2];
                     wdout_q   <= wdin;
                     dev_we_q  <= wecpu ? dec_oh : '0;
                     dev_re_q  <= wecpu ? '0 : dec_oh;
                     busy_q    <= 1'b1;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
                     cnt_q     <= '0;
`endif
                  end else begin
                     done_q   <= 1'b1;
                     buserr_q <= 1'b1;
                     rd_q     <= '0;
                  end
               end
            end
            StAcc: begin
               if (ready_sel) begin
                  if (!we_q) begin
                     rd_q <= rd_sel;
                  end
                  state_q  <= StIdle;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  dev_we_q <= '0;
                  dev_re_q <= '0;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
               end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                  state_q  <= StIdle;
                  done_q   <= 1'b1;
                  buserr_q <= 1'b1;
                  rd_q     <= '0;
                  busy_q   <= 1'b0;
                  dev_we_q <= '0;
                  dev_re_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
`endif
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rd       = rd_q;
   assign done     = done_q;
   assign buserr   = buserr_q;
   assign busy     = busy_q;
   assign outaddr  = outaddr_q;
   assign wdout    = wdout_q;
   assign dev_we   = dev_we_q;
   assign dev_re   = dev_re_q;
   assign hwintout = hwint_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed cases plus randomized transactions vs a
// transaction-level model (address windows, latency, held read data).
module tb_mmio_bridge;

   localparam int unsigned NDEV        = 3;
   localparam logic [31:0] BASE_ADDR   = 32'h0000_7F00;
   localparam int unsigned SPAN_LOG2   = 4;
   localparam int unsigned NINT        = 6;
   localparam int unsigned TIMEOUT_CYC = 16;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   reset;
   logic [31:0]            praddr, wdin;
   logic                   wecpu, recpu;
   logic [31:0]            rd;
   logic                   done, buserr, busy;
   logic [SPAN_LOG2-3:0]   outaddr;
   logic [31:0]            wdout;
   logic [NDEV-1:0]        dev_we, dev_re;
   logic [NDEV*32-1:0]     dev_rd;
   logic [NDEV-1:0]        dev_ready;
   logic [NINT-1:0]        hwintin, hwintout;

   int checks = 0;
   int errors = 0;
   logic [31:0] rd_exp = '0;

   mmio_bridge #(
      .NDEV        (NDEV),
      .BASE_ADDR   (BASE_ADDR),
      .SPAN_LOG2   (SPAN_LOG2),
      .NINT        (NINT),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .praddr    (praddr),
      .wdin      (wdin),
      .wecpu     (wecpu),
      .recpu     (recpu),
      .rd        (rd),
      .done      (done),
      .buserr    (buserr),
      .busy      (busy),
      .outaddr   (outaddr),
      .wdout     (wdout),
      .dev_we    (dev_we),
      .dev_re    (dev_re),
      .dev_rd    (dev_rd),
      .dev_ready (dev_ready),
      .hwintin   (hwintin),
      .hwintout  (hwintout)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (observed hang, required finish)");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One CPU transaction; dly = ACC cycles before the device raises ready, -1 = never.
   task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                      input logic re, input int dly, input logic [31:0] data);
      longint        a;
      bit            hit, tmo, wr;
      int            idx, acc_cycles;
      logic [NDEV-1:0] oh;
      logic [SPAN_LOG2-3:0] woff;
      a    = longint'(addr);
      hit  = (a >= longint'(BASE_ADDR)) &&
             (a < longint'(BASE_ADDR) + longint'(NDEV) * (longint'(1) << SPAN_LOG2));
      idx  = hit ? int'((a - longint'(BASE_ADDR)) >> SPAN_LOG2) : 0;
      oh   = hit ? NDEV'(1 << idx) : '0;
      wr   = we;
      tmo  = TimeoutEn && hit && (dly < 0 || dly >= int'(TIMEOUT_CYC));
      acc_cycles = !hit ? 0 : (tmo ? int'(TIMEOUT_CYC) : dly + 1);
      woff = addr[SPAN_LOG2-1:2];

      @(posedge clk); #1;
      praddr = addr; wdin = wdata; wecpu = we; recpu = re;
      for (int i = 0; i < NDEV; i++) dev_rd[i*32 +: 32] = $urandom;
      if (hit) dev_rd[idx*32 +: 32] = data;
      dev_ready = '0;

      for (int k = 1; k <= acc_cycles; k++) begin
         @(posedge clk); #1;
         dev_ready      = NDEV'($urandom);
         dev_ready[idx] = !tmo && (k == acc_cycles);
         @(negedge clk);
         check("acc_busy", busy, 1'b1);
         check("acc_done", done, 1'b0);
         check("acc_we", dev_we, wr ? oh : '0);
         check("acc_re", dev_re, wr ? '0 : oh);
         check("acc_outaddr", outaddr, woff);
         check("acc_wdout", wdout, wdata);
      end

      @(posedge clk); #1;
      wecpu = 1'b0; recpu = 1'b0; dev_ready = '0;
      if (!hit || tmo) rd_exp = '0;
      else if (!wr) rd_exp = data;
      @(negedge clk);
      check("cpl_done", done, 1'b1);
      check("cpl_buserr", buserr, !hit || tmo);
      check("cpl_rd", rd, rd_exp);
      check("cpl_busy", busy, 1'b0);
      check("cpl_we", dev_we, '0);
      check("cpl_re", dev_re, '0);

      @(posedge clk); #1;
      @(negedge clk);
      check("post_done", done, 1'b0);
      check("post_buserr", buserr, 1'b0);
      check("post_rd", rd, rd_exp);
   endtask

   initial begin
      logic [NINT-1:0] hw_prev;
      logic [31:0]     addr;
      int              op;

      reset = 1'b1; praddr = '0; wdin = '0; wecpu = 1'b0; recpu = 1'b0;
      dev_rd = '0; dev_ready = '0; hwintin = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rd", rd, 32'h0);
      check("rst_done", done, 1'b0);
      check("rst_buserr", buserr, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_we", dev_we, '0);
      check("rst_re", dev_re, '0);
      check("rst_outaddr", outaddr, '0);
      check("rst_wdout", wdout, 32'h0);
      check("rst_hwint", hwintout, '0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Interrupt pass-through: one register stage.
      hwintin = 6'b100001;
      @(negedge clk);
      check("hwint_before", hwintout, 6'b000000);
      @(posedge clk); #1;
      @(negedge clk);
      check("hwint_after", hwintout, 6'b100001);
      hw_prev = hwintin;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         hwintin = NINT'($urandom);
         @(negedge clk);
         check("hwint_hold", hwintout, hw_prev);
         @(posedge clk); #1;
         hw_prev = hwintin;
         @(negedge clk);
         check("hwint_rand", hwintout, hw_prev);
      end

      // Directed: write to dev1 word 1, ready immediately.
      txn(32'h7F14, 32'hA5A5_0001, 1'b1, 1'b0, 0, 32'h0);
      // Directed: read dev2, ready after 3 extra cycles.
      txn(32'h7F20, 32'h0, 1'b0, 1'b1, 3, 32'h0000_00FF);
      // Directed: just past the last window -> bus error.
      txn(32'h7F30, 32'h0, 1'b0, 1'b1, 0, 32'h0);
      // Directed: write and read together -> write only.
      txn(32'h7F08, 32'h1234_5678, 1'b1, 1'b1, 1, 32'hDEAD_BEEF);
      // Directed: just below the base -> bus error.
      txn(32'h7EFC, 32'h0, 1'b0, 1'b1, 0, 32'h0);

      // Device never ready.
      if (TimeoutEn) begin
         txn(32'h7F00, 32'h0, 1'b0, 1'b1, -1, 32'h0);
      end else begin
         @(posedge clk); #1;
         praddr = 32'h7F00; recpu = 1'b1; dev_ready = '0;
         for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            dev_ready    = NDEV'($urandom);
            dev_ready[0] = 1'b0;
            @(negedge clk);
            check("stuck_busy", busy, 1'b1);
            check("stuck_done", done, 1'b0);
         end
         @(posedge clk); #1;
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0; recpu = 1'b0; dev_ready = '0;
         rd_exp = '0;
         @(negedge clk);
         check("stuck_rst_busy", busy, 1'b0);
         check("stuck_rst_re", dev_re, '0);
      end

      // Reset on the second ACC cycle aborts without a done pulse.
      txn(32'h7F24, 32'h0, 1'b0, 1'b1, 0, 32'hCAFE_0042);
      @(posedge clk); #1;
      praddr = 32'h7F14; recpu = 1'b1; dev_ready = '0;
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_acc1_re", dev_re, 3'b010);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("abort_acc2_re", dev_re, 3'b010);
      @(posedge clk); #1;
      reset = 1'b0; recpu = 1'b0;
      rd_exp = '0;
      @(negedge clk);
      check("abort_re", dev_re, '0);
      check("abort_we", dev_we, '0);
      check("abort_done", done, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_rd", rd, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_done2", done, 1'b0);
      txn(32'h7F18, 32'h0, 1'b0, 1'b1, 2, 32'h0BAD_F00D);

      // Randomized traffic across and around the windows.
      for (int n = 0; n < 60; n++) begin
         addr = 32'h7EE0 + 32'($urandom_range(0, 27)) * 32'd4;
         if ($urandom_range(0, 9) == 0) addr = $urandom;
         op = $urandom_range(0, 2);
         txn(addr, $urandom, op != 1, op != 0, $urandom_range(0, 5), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
